// File: rtl/regbank_write_sched.sv
// rtl/regbank_write_sched.sv - register bank write-port scheduler: zero-init, wb/load arbitration, pending scoreboard
// Optional REGBANK_ZERO_PROTECT_EN: RUN-state writes to register 0 are consumed without driving Reg_write.
module regbank_write_sched #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_req,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        ld_req,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  output logic        ld_ack,
  output logic        wb_stall,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  rd_reg1,
  input  logic [4:0]  rd_reg2,
  output logic        hazard,
  output logic [31:0] pending,
  output logic        busy,
  output logic        Reg_write,
  output logic [4:0]  write_register,
  output logic [31:0] write_data
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
`ifdef REGBANK_ZERO_PROTECT_EN
  localparam bit ZERO_PROT = 1'b1;
`else
  localparam bit ZERO_PROT = 1'b0;
`endif

  logic [0:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          we_q, we_d;
  logic [4:0]    wr_reg_q, wr_reg_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [31:0]   pending_q, pending_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          run;
  logic          force_ld;
  logic          grant;
  logic [4:0]    grant_reg;
  logic [31:0]   grant_data;

  always_comb begin
    run        = (state_q == S_RUN);
    force_ld   = run && ld_req && (starve_q == STARVE_MAX);
    ld_ack     = run && ld_req && (!wb_req || force_ld);
    wb_stall   = wb_req && (!run || force_ld);
    hazard     = !run || pending_q[rd_reg1] || pending_q[rd_reg2];
    grant      = ld_ack || (run && wb_req);
    grant_reg  = ld_ack ? ld_reg  : wb_reg;
    grant_data = ld_ack ? ld_data : wb_data;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    we_d      = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    pending_d = pending_q;
    starve_d  = starve_q;
    if (!run) begin
      we_d      = 1'b1;
      wr_reg_d  = cnt_q;
      wr_data_d = 32'd0;
      starve_d  = '0;
      // cnt parks at 31 so the sequence can only restart through reset
      if (cnt_q == 5'd31) begin
        state_d = S_RUN;
        busy_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else begin
      if (grant && !(ZERO_PROT && grant_reg == 5'd0)) begin
        we_d      = 1'b1;
        wr_reg_d  = grant_reg;
        wr_data_d = grant_data;
      end
      if (ld_req && !ld_ack)
        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_ONE;
      else
        starve_d = '0;
      // clear first so a same-edge issue to the same register wins
      if (ld_ack)
        pending_d[ld_reg] = 1'b0;
      if (issue_valid && !(ZERO_PROT && issue_reg == 5'd0))
        pending_d[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b1;
      we_q      <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
      pending_q <= 32'd0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end

  assign pending        = pending_q;
  assign busy           = busy_q;
  assign Reg_write      = we_q;
  assign write_register = wr_reg_q;
  assign write_data     = wr_data_q;

endmodule

// File: tb/tb_regbank_write_sched.sv
// tb/tb_regbank_write_sched.sv - self-checking bench for regbank_write_sched
// Expected write-port values are queued per cycle and compared one edge later by a monitor.
module tb_regbank_write_sched;

  typedef struct packed {
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_req = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        ld_req = 1'b0;
  logic [4:0]  ld_reg = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ack, wb_stall;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic [4:0]  rd_reg1 = '0;
  logic [4:0]  rd_reg2 = '0;
  logic        hazard;
  logic [31:0] pending;
  logic        busy;
  logic        Reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;

  int n_checks = 0;
  int n_fail = 0;
  wr_t sb[$];
  wr_t mon_e;
  logic [4:0]  last_r = '0;
  logic [31:0] last_d = '0;

  regbank_write_sched #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_reg(wb_reg), .wb_data(wb_data),
    .ld_req(ld_req), .ld_reg(ld_reg), .ld_data(ld_data),
    .ld_ack(ld_ack), .wb_stall(wb_stall),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .hazard(hazard), .pending(pending), .busy(busy),
    .Reg_write(Reg_write), .write_register(write_register), .write_data(write_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if ({Reg_write, write_register, write_data} !== mon_e)
        $display("FAIL write_port: got we=%b reg=%0d data=%h want we=%b reg=%0d data=%h",
                 Reg_write, write_register, write_data, mon_e.we, mon_e.r, mon_e.d);
      if ({Reg_write, write_register, write_data} !== mon_e) n_fail++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] r, input logic [31:0] d);
    if (we) begin
      last_r = r;
      last_d = d;
    end
    sb.push_back({we, last_r, last_d});
  endtask

  task automatic idle_inputs();
    wb_req = 1'b0; ld_req = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    step(); step();
    n_checks++;
    if ({Reg_write, write_register, write_data} !== 38'd0) begin
      n_fail++; $display("FAIL reset_port: got %b/%0d/%h want 0/0/0", Reg_write, write_register, write_data);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_checks++;
    if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_checks++;
    if (hazard !== 1'b1) begin n_fail++; $display("FAIL reset_hazard: got %b want 1", hazard); end
  endtask

  task automatic test_init();
    rst = 1'b1;
    last_r = '0; last_d = '0;
    for (int k = 0; k < 32; k++) begin
      #3;
      n_checks++;
      if ({busy, hazard} !== 2'b11) begin
        n_fail++; $display("FAIL init_busy_hazard step %0d: got %b%b want 11", k, busy, hazard);
      end
      push_exp(1'b1, 5'(k), 32'd0);
      step();
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL init_done_busy: got %b want 0", busy); end
    #3;
    n_checks++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL run_idle_hazard: got %b want 0", hazard); end
    push_exp(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_priority();
    wb_req = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
    ld_req = 1'b1; ld_reg = 5'd7; ld_data = 32'hABCD;
    #3;
    n_checks++;
    if ({ld_ack, wb_stall} !== 2'b00) begin
      n_fail++; $display("FAIL prio_ack_stall: got %b%b want 00", ld_ack, wb_stall);
    end
    push_exp(1'b1, 5'd5, 32'h1234);
    step();
    idle_inputs();
    #3 push_exp(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_starve();
    for (int i = 0; i < 9; i++) begin
      wb_req = 1'b1; wb_reg = 5'd3; wb_data = 32'h100 + i;
      ld_req = 1'b1; ld_reg = 5'd7; ld_data = 32'hCAFE;
      #3;
      n_checks++;
      if ({ld_ack, wb_stall} !== {2{i == 8}}) begin
        n_fail++; $display("FAIL starve_cycle %0d: got ack=%b stall=%b want %b", i, ld_ack, wb_stall, i == 8);
      end
      if (i == 8) push_exp(1'b1, 5'd7, 32'hCAFE);
      else        push_exp(1'b1, 5'd3, 32'h100 + i);
      step();
    end
    ld_req = 1'b0; wb_data = 32'h200;
    #3;
    n_checks++;
    if ({ld_ack, wb_stall} !== 2'b00) begin
      n_fail++; $display("FAIL starve_after: got %b%b want 00", ld_ack, wb_stall);
    end
    push_exp(1'b1, 5'd3, 32'h200);
    step();
    idle_inputs();
    #3 push_exp(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_reg = 5'd9;
    #3 push_exp(1'b0, 5'd0, 32'd0);
    step();
    issue_valid = 1'b0; rd_reg1 = 5'd9; rd_reg2 = 5'd1;
    #3;
    n_checks++;
    if ({hazard, pending} !== {1'b1, 32'h200}) begin
      n_fail++; $display("FAIL sb_set: got hazard=%b pending=%h want 1/00000200", hazard, pending);
    end
    push_exp(1'b0, 5'd0, 32'd0);
    step();
    ld_req = 1'b1; ld_reg = 5'd9; ld_data = 32'h99;
    #3;
    n_checks++;
    if (ld_ack !== 1'b1) begin n_fail++; $display("FAIL sb_ld_ack: got %b want 1", ld_ack); end
    push_exp(1'b1, 5'd9, 32'h99);
    step();
    ld_req = 1'b0;
    #3;
    n_checks++;
    if ({hazard, pending} !== 33'd0) begin
      n_fail++; $display("FAIL sb_clear: got hazard=%b pending=%h want 0/0", hazard, pending);
    end
    push_exp(1'b0, 5'd0, 32'd0);
    step();
    issue_valid = 1'b1; issue_reg = 5'd9; ld_req = 1'b1; ld_data = 32'h77;
    #3 push_exp(1'b1, 5'd9, 32'h77);
    step();
    issue_valid = 1'b0; ld_req = 1'b0;
    wb_req = 1'b1; wb_reg = 5'd9; wb_data = 32'h55;
    #3;
    n_checks++;
    if ({hazard, pending} !== {1'b1, 32'h200}) begin
      n_fail++; $display("FAIL sb_set_wins: got hazard=%b pending=%h want 1/00000200", hazard, pending);
    end
    push_exp(1'b1, 5'd9, 32'h55);
    step();
    wb_req = 1'b0; ld_req = 1'b1; ld_data = 32'h66;
    #3;
    n_checks++;
    if (pending !== 32'h200) begin n_fail++; $display("FAIL sb_wb_keeps: got %h want 00000200", pending); end
    push_exp(1'b1, 5'd9, 32'h66);
    step();
    ld_req = 1'b0; rd_reg1 = 5'd0;
    #3;
    n_checks++;
    if (pending !== 32'd0) begin n_fail++; $display("FAIL sb_final: got %h want 0", pending); end
    push_exp(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_zero();
    wb_req = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF;
    #3;
    n_checks++;
    if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", wb_stall); end
`ifdef REGBANK_ZERO_PROTECT_EN
    push_exp(1'b0, 5'd0, 32'd0);
`else
    push_exp(1'b1, 5'd0, 32'hFFFF);
`endif
    step();
    idle_inputs();
    #3 push_exp(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_reset_mid_init();
    issue_valid = 1'b1; issue_reg = 5'd4;
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    last_r = '0; last_d = '0;
    for (int k = 0; k < 13; k++) begin
      wb_req = (k == 5); ld_req = (k == 5); ld_reg = 5'd2;
      #3;
      if (k == 5) begin
        n_checks++;
        if ({ld_ack, wb_stall} !== 2'b01) begin
          n_fail++; $display("FAIL init_arb: got ack=%b stall=%b want 0/1", ld_ack, wb_stall);
        end
      end
      push_exp(1'b1, 5'(k), 32'd0);
      step();
    end
    idle_inputs();
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({Reg_write, write_register, busy, pending} !== {1'b0, 5'd0, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL midinit_reset: got we=%b reg=%0d busy=%b pending=%h want 0/0/1/0",
                         Reg_write, write_register, busy, pending);
    end
    step();
    rst = 1'b1;
    last_r = '0; last_d = '0;
    for (int k = 0; k < 3; k++) begin
      #3 push_exp(1'b1, 5'(k), 32'd0);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_priority();
    test_starve();
    test_scoreboard();
    test_zero();
    test_reset_mid_init();
    step();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_write_sched.md
REGBANK_WRITE_SCHED -- requirements
Module: regbank_write_sched

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive denied cycles of the load requester before it is forced through.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 wb_req  input  1  writeback-stage write request.
REQ-005 wb_reg / wb_data  input  5 / 32  writeback destination register and data.
REQ-006 ld_req  input  1  multicycle/load unit write request, held until ld_ack.
REQ-007 ld_reg / ld_data  input  5 / 32  load destination register and data, stable while ld_req is high.
REQ-008 ld_ack  output  1  combinational: load request granted this cycle.
REQ-009 wb_stall  output  1  combinational: writeback request not accepted this cycle; upstream holds it.
REQ-010 issue_valid / issue_reg  input  1 / 5  a multicycle op issued with this destination.
REQ-011 rd_reg1 / rd_reg2  input  5 / 5  source registers of the instruction in decode.
REQ-012 hazard  output  1  combinational: a source register has a pending write, or init is in progress.
REQ-013 pending  output  32  scoreboard, bit i set = register i awaiting a load write.
REQ-014 busy  output  1  registered: init sequence in progress.
REQ-015 Reg_write / write_register / write_data  output  1 / 5 / 32  registered drive to the register bank write port.

Function
REQ-016 FSM states INIT and RUN; INIT entered on reset.
REQ-017 INIT: 5-bit counter cnt steps 0..31, one register per cycle; Reg_write=1, write_register=cnt, write_data=0 on the cycle after each step.
REQ-018 INIT: ld_ack=0, wb_stall=wb_req, hazard=1, busy=1.
REQ-019 Transition INIT->RUN occurs on the cycle after cnt=31 is issued; busy falls on the same edge; cnt does not wrap back into INIT.
REQ-020 RUN default priority: wb_req granted; ld_ack = ld_req & ~wb_req.
REQ-021 Starvation counter: increments each RUN cycle with ld_req=1 and ld_ack=0; clears when ld_ack=1 or ld_req=0; saturates at STARVE_LIMIT.
REQ-022 When the counter equals STARVE_LIMIT and ld_req=1: ld_ack=1, and wb_stall=wb_req for that cycle only.
REQ-023 Granted request in cycle N appears on Reg_write/write_register/write_data at cycle N+1 (latency 1); with no grant, Reg_write=0 and write_register/write_data hold their last values.
REQ-024 Scoreboard: issue_valid sets pending[issue_reg]; ld_ack clears pending[ld_reg] on the same edge.
REQ-025 Simultaneous set and clear of the same bit: set wins.
REQ-026 hazard = pending[rd_reg1] | pending[rd_reg2] in RUN; a wb write never clears pending.
REQ-027 issue_valid during INIT is ignored.

Reset
REQ-028 rst low asynchronously forces: state=INIT, cnt=0, busy=1, Reg_write=0, write_register=0, write_data=0, pending=0, starvation counter=0.
REQ-029 Reset asserted mid-INIT or mid-RUN aborts any in-flight grant; the INIT sequence restarts from register 0 after release.

Configuration
REQ-030 Macro REGBANK_ZERO_PROTECT_EN defined: RUN-state grants with destination register 0 are acked/consumed but produce Reg_write=0; issue_reg=0 never sets pending[0]; INIT still writes register 0.
REQ-031 Macro REGBANK_ZERO_PROTECT_EN undefined: register 0 is treated like every other register.

Verification
REQ-032 Release reset, idle inputs -> Reg_write=1 for 32 consecutive cycles with write_register 0..31 and data 0; busy falls after the 32nd write; hazard=1 throughout.
REQ-033 RUN, wb_req=1 (reg 5, 0x1234) and ld_req=1 (reg 7) same cycle -> next cycle Reg_write=1, write_register=5, data=0x1234; ld_ack=0.
REQ-034 RUN, wb_req held high 9 cycles with ld_req=1, STARVE_LIMIT=8 -> the 9th cycle ld_ack=1, wb_stall=1; next cycle write_register=7 with ld_data.
REQ-035 issue_valid reg 9, then rd_reg1=9 -> hazard=1; ld write to reg 9 granted -> pending[9]=0 the next cycle, hazard=0; same-cycle issue and ack of reg 9 -> pending[9] stays 1.
REQ-036 REGBANK_ZERO_PROTECT_EN defined, wb_req reg 0 data 0xFFFF -> wb_stall=0, Reg_write=0 next cycle; undefined -> Reg_write=1, write_register=0.
REQ-037 rst pulsed low at INIT step 12 -> outputs at reset values immediately; after release INIT restarts at register 0.
